// File: rtl/act_buf_line_reader.sv
// act_buf_line_reader: strided line-read initiator with a credit-limited output FIFO
module act_buf_line_reader #(
  parameter int addrWidth = 18,
  parameter int lineWidth = 256,
  parameter int lenWidth  = 16,
  parameter int fifoDepth = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [addrWidth-1:0] base_addr_i,
  input  logic [addrWidth-1:0] stride_i,
  input  logic [lenWidth-1:0]  num_lines_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [addrWidth-1:0] rd_addr_o,
  input  logic [lineWidth-1:0] rd_data_i,
  output logic                 m_valid_o,
  output logic [lineWidth-1:0] m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);
  localparam int pw = $clog2(fifoDepth);
  localparam int cw = $clog2(fifoDepth + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_d;
  logic [addrWidth-1:0] addr_q, stride_q;
  logic [lenWidth-1:0] issue_cnt, pop_cnt;
  logic inflight_q, done_q, done_d, pop;
  logic [lineWidth-1:0] mem [fifoDepth];
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count;
  logic [cw:0] occ;
  function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
    return p == pw'(fifoDepth - 1) ? '0 : p + 1'b1;
  endfunction
  assign pop = m_valid_o && m_ready_i;
  assign m_valid_o = count != '0;
  assign m_data_o = m_valid_o ? mem[rd_ptr] : '0;
  assign m_last_o = m_valid_o && pop_cnt == lenWidth'(1);
  assign busy_o = state != IDLE;
  assign done_o = done_q;
  // Occupancy includes the line still in flight so a capture never overflows.
  assign occ = (cw + 1)'(count) + (cw + 1)'(inflight_q);
  assign rd_en_o = state == RUN && issue_cnt != '0 && occ < (cw + 1)'(fifoDepth) + (cw + 1)'(pop);
  assign rd_addr_o = rd_en_o ? addr_q : '0;
  // Run sequencing: zero-length starts finish without leaving IDLE.
  always_comb begin
    state_d = state;
    done_d = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = start_i && num_lines_i != '0 ? RUN : IDLE;
        done_d = start_i && num_lines_i == '0;
      end
      RUN: state_d = rd_en_o && issue_cnt == lenWidth'(1) ? DRAIN : RUN;
      DRAIN: begin
        done_d = pop && pop_cnt == lenWidth'(1);
        state_d = done_d ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control state, address walk, counters and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done_q <= 1'b0;
      inflight_q <= 1'b0;
      addr_q <= '0;
      stride_q <= '0;
      issue_cnt <= '0;
      pop_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_d;
      done_q <= done_d;
      inflight_q <= rd_en_o;
      if (state == IDLE && start_i) begin
        addr_q <= base_addr_i;
        stride_q <= stride_i;
        issue_cnt <= num_lines_i;
        pop_cnt <= num_lines_i;
      end else begin
        if (rd_en_o) begin
          addr_q <= addr_q + stride_q;
          issue_cnt <= issue_cnt - lenWidth'(1);
        end
        if (pop) pop_cnt <= pop_cnt - lenWidth'(1);
      end
      if (inflight_q) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + cw'(inflight_q) - cw'(pop);
    end
  end
  // Line storage; data returns the cycle after the read enable.
  always_ff @(posedge clk) begin
    if (inflight_q) mem[wr_ptr] <= rd_data_i;
  end
endmodule
